bitr_reorder_ctrl: RTL and testbench

- Streaming reorder controller for the 15-point 5x3 transpose index map (k -> 3k mod 14 for k<14, 14 -> 14).
- Accepts samples in natural order and stores each frame in one bank of a two-bank ping-pong buffer.
- Replays each full frame in permuted order through a valid/ready output.
- Sits between the input stage and the next transform stage; computes the permuted addresses itself, so no lookup table is needed.

---
 rtl/bitr_reorder_ctrl_pkg.sv | 34 +++
 rtl/bitr_reorder_ctrl_addr_gen.sv | 74 +++++++
 rtl/bitr_reorder_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bitr_reorder_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitr_reorder_ctrl_pkg.sv
// ============================================================================
// Module      : bitr_pkg
// Description : Shared constants, bank-state encoding and the golden
//               transpose map for the 15-point 5x3 reorder controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitr_pkg;

    localparam int ROWS  = 5;
    localparam int COLS  = 3;
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);

    // Per-bank life cycle of the ping-pong buffer.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Golden transpose map: k -> COLS*k mod (N-1) for k < N-1, last slot fixed.
    function automatic int perm_ref(input int k);
        if (k < N - 1) begin
            return (k * COLS) % (N - 1);
        end
        return N - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitr_reorder_ctrl_addr_gen.sv
// ============================================================================
// Module      : bitr_addr_gen
// Description : Incremental read-address generator for the transpose map.
//               Produces 0, COLS, 2*COLS, ... folded modulo N-1, with the
//               final slot forced to N-1. No lookup table.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               start  - restart the sequence at slot 0
//               step   - advance to the next slot (wraps after slot N-1)
//               addr   - address for the current slot
//               last   - current slot is N-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitr_addr_gen
    import bitr_pkg::*;
#(
    parameter int ROWS_P  = 5,
    parameter int COLS_P  = 3,
    parameter int IDX_W_P = $clog2(ROWS_P * COLS_P)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    output logic [IDX_W_P-1:0] addr,
    output logic               last
);

    localparam int                 NP       = ROWS_P * COLS_P;
    localparam logic [IDX_W_P-1:0] LAST_IDX = IDX_W_P'(NP - 1);
    localparam logic [IDX_W_P:0]   C_STRIDE = (IDX_W_P + 1)'(COLS_P);
    localparam logic [IDX_W_P:0]   C_MOD    = (IDX_W_P + 1)'(NP - 1);

    logic [IDX_W_P-1:0] r_addr;
    logic [IDX_W_P-1:0] r_k;
    logic [IDX_W_P:0]   w_sum;
    logic [IDX_W_P:0]   w_fold;

    // One extra bit so the stride add cannot overflow before folding.
    always_comb begin
        w_sum  = {1'b0, r_addr} + C_STRIDE;
        w_fold = w_sum;
        if (w_sum >= C_MOD) begin
            w_fold = w_sum - C_MOD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            r_addr <= '0;
            r_k    <= '0;
        end else if (step) begin
            if (r_k == LAST_IDX) begin
                r_addr <= '0;
                r_k    <= '0;
            end else if (r_k == LAST_IDX - 1'b1) begin
                // The final slot sits outside the modulo ring.
                r_addr <= LAST_IDX;
                r_k    <= r_k + 1'b1;
            end else begin
                r_addr <= w_fold[IDX_W_P-1:0];
                r_k    <= r_k + 1'b1;
            end
        end
    end

    assign addr = r_addr;
    assign last = (r_k == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/bitr_reorder_ctrl.sv
// ============================================================================
// Module      : bitr_reorder_ctrl
// Description : Streaming 15-point 5x3 transpose reorder controller. Frames
//               arrive in natural order, are stored in one bank of a two-bank
//               ping-pong buffer and are replayed in permuted order.
// Options     : BITR_REORDER_BYPASS_EN adds cfg_bypass; a bank tagged with
//               bypass when it becomes full is replayed in natural order.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               s_valid/s_ready     - input handshake
//               s_data  [DW]        - input sample, natural order
//               m_valid/m_ready     - output handshake
//               m_data  [DW]        - output sample, permuted order
//               m_last              - output slot N-1
//               busy                - any bank full/draining or m_valid high
//               cfg_bypass          - (option) natural-order replay request
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitr_reorder_ctrl #(
    parameter int DW   = 16,
    parameter int ROWS = 5,
    parameter int COLS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
`ifdef BITR_REORDER_BYPASS_EN
    input  logic          cfg_bypass,
`endif
    output logic          busy
);

    import bitr_pkg::*;

    localparam int               N        = ROWS * COLS;
    localparam int               IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    bank_state_e      r_bank_st [2];
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [IDX_W-1:0] r_wr_idx;
    logic [DW-1:0]    r_mem [2][N];

    logic             w_wr;
    logic             w_rd_avail;
    logic             w_load;
    logic             w_rd_last;
    logic [IDX_W-1:0] w_perm_addr;
    logic [IDX_W-1:0] w_rd_addr;

    bitr_addr_gen #(
        .ROWS_P  (ROWS),
        .COLS_P  (COLS),
        .IDX_W_P (IDX_W)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (1'b0),
        .step  (w_load),
        .addr  (w_perm_addr),
        .last  (w_rd_last)
    );

    // Writer only ever owns an EMPTY/FILLING bank and the reader a
    // FULL/DRAINING one, so the two sides never touch the same bank.
    assign s_ready    = (r_bank_st[r_wr_sel] == BANK_EMPTY) ||
                        (r_bank_st[r_wr_sel] == BANK_FILLING);
    assign w_wr       = s_valid && s_ready;
    assign w_rd_avail = (r_bank_st[r_rd_sel] == BANK_FULL) ||
                        (r_bank_st[r_rd_sel] == BANK_DRAINING);
    assign w_load     = (!m_valid || m_ready) && w_rd_avail;

`ifdef BITR_REORDER_BYPASS_EN
    logic             r_bypass [2];
    logic [IDX_W-1:0] r_rd_k;

    // Natural-order replay uses the slot index directly as the address.
    assign w_rd_addr = r_bypass[r_rd_sel] ? r_rd_k : w_perm_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bypass[0] <= 1'b0;
            r_bypass[1] <= 1'b0;
            r_rd_k      <= '0;
        end else begin
            if (w_wr && (r_wr_idx == LAST_IDX)) begin
                r_bypass[r_wr_sel] <= cfg_bypass;
            end
            if (w_load) begin
                r_rd_k <= w_rd_last ? '0 : r_rd_k + 1'b1;
            end
        end
    end
`else
    assign w_rd_addr = w_perm_addr;
`endif

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_sel][r_wr_idx] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
            r_wr_sel     <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_wr_idx     <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_last       <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr && (r_wr_sel == 1'(b))) begin
                    if (r_wr_idx == LAST_IDX) begin
                        r_bank_st[b] <= BANK_FULL;
                    end else begin
                        r_bank_st[b] <= BANK_FILLING;
                    end
                end
                if (w_load && (r_rd_sel == 1'(b))) begin
                    if (w_rd_last) begin
                        r_bank_st[b] <= BANK_EMPTY;
                    end else begin
                        r_bank_st[b] <= BANK_DRAINING;
                    end
                end
            end

            if (w_wr) begin
                if (r_wr_idx == LAST_IDX) begin
                    r_wr_idx <= '0;
                    r_wr_sel <= ~r_wr_sel;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end

            if (w_load) begin
                m_valid <= 1'b1;
                m_data  <= r_mem[r_rd_sel][w_rd_addr];
                m_last  <= w_rd_last;
                if (w_rd_last) begin
                    r_rd_sel <= ~r_rd_sel;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = m_valid;
        for (int b = 0; b < 2; b++) begin
            if ((r_bank_st[b] == BANK_FULL) || (r_bank_st[b] == BANK_DRAINING)) begin
                busy = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitr_reorder_ctrl.sv
// ============================================================================
// Module      : tb_bitr_reorder_ctrl
// Description : Self-checking bench for bitr_reorder_ctrl and bitr_addr_gen.
//               A frame-level scoreboard applies the transpose map to every
//               completed input frame and compares the replayed stream.
//               Define BITR_REORDER_BYPASS_EN to exercise natural-order replay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitr_reorder_ctrl;

    import bitr_pkg::*;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
`ifdef BITR_REORDER_BYPASS_EN
    logic          cfg_bypass;
`endif

    logic             ag_start;
    logic             ag_step;
    logic [IDX_W-1:0] ag_addr;
    logic             ag_last;

    bitr_reorder_ctrl #(.DW(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
`ifdef BITR_REORDER_BYPASS_EN
        .cfg_bypass (cfg_bypass),
`endif
        .busy       (busy)
    );

    bitr_addr_gen #(.ROWS_P(ROWS), .COLS_P(COLS), .IDX_W_P(IDX_W)) u_ag (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ag_start),
        .step  (ag_step),
        .addr  (ag_addr),
        .last  (ag_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;

    logic [DW-1:0] in_frame [$];
    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];

    logic          hold_pending = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    logic          obs_sr, obs_mv, obs_ml, obs_busy;
    logic [DW-1:0] obs_md;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, observe at the falling edge, update the model.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic bp;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        obs_sr = s_ready; obs_mv = m_valid; obs_md = m_data;
        obs_ml = m_last;  obs_busy = busy;
        if (hold_pending && rst_n) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hold_data);
            check("hold_last", m_last, hold_last);
        end
        hold_pending = 1'b0;
        if (!rst_n) begin
            in_frame.delete();
            exp_data.delete();
            exp_last.delete();
        end else begin
            if (sv && s_ready) begin
                in_frame.push_back(sd);
                n_acc++;
                if (in_frame.size() == N) begin
                    bp = 1'b0;
`ifdef BITR_REORDER_BYPASS_EN
                    bp = cfg_bypass;
`endif
                    for (int k = 0; k < N; k++) begin
                        exp_data.push_back(bp ? in_frame[k] : in_frame[perm_ref(k)]);
                        exp_last.push_back(k == N - 1);
                    end
                    in_frame.delete();
                end
            end
            if (m_valid && mr) begin
                check("out_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    check("data", m_data, exp_data.pop_front());
                    check("last", m_last, exp_last.pop_front());
                    n_out++;
                end
            end
            if (m_valid && !mr) begin
                hold_pending = 1'b1;
                hold_data    = m_data;
                hold_last    = m_last;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_idle(input string tag);
        int guard = 0;
        while (exp_data.size() != 0 && guard < 300) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        check({tag, "_drain_bound"}, guard < 300, 1);
        step(1'b0, '0, 1'b1);
        check({tag, "_idle_valid"}, obs_mv, 0);
        check({tag, "_idle_busy"}, obs_busy, 0);
        check({tag, "_idle_ready"}, obs_sr, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, obs_sr, 1);
        check({tag, "_m_valid"}, obs_mv, 0);
        check({tag, "_m_data"}, obs_md, 0);
        check({tag, "_m_last"}, obs_ml, 0);
        check({tag, "_busy"}, obs_busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int acc0, out0, stalls, gaps, pre_acc, pre_out, guard;
        logic started;

        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        ag_start = 1'b0; ag_step = 1'b0;
`ifdef BITR_REORDER_BYPASS_EN
        cfg_bypass = 1'b0;
`endif

        // Reset state.
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Standalone address generator over every slot plus the wrap.
        ag_start = 1'b1;
        @(posedge clk); #1;
        ag_start = 1'b0;
        ag_step  = 1'b1;
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            check("ag_addr", ag_addr, perm_ref(k % N));
            check("ag_last", ag_last, (k % N) == N - 1);
            @(posedge clk); #1;
        end
        ag_step = 1'b0;

        // Single frame 100..114 and first-output latency.
        for (int i = 0; i < N; i++) begin
            step(1'b1, DW'(100 + i), 1'b1);
        end
        step(1'b0, '0, 1'b1);
        check("lat_valid_low", obs_mv, 0);
        check("lat_busy", obs_busy, 1);
        step(1'b0, '0, 1'b1);
        check("lat_valid_high", obs_mv, 1);
        check("lat_first_data", obs_md, 100);
        drain_and_idle("single");

        // Four back-to-back frames at full rate.
        acc0 = n_acc; out0 = n_out; stalls = 0; gaps = 0; started = 1'b0;
        for (int c = 0; c < 200 && (n_out - out0) < 4 * N; c++) begin
            pre_acc = n_acc - acc0;
            pre_out = n_out - out0;
            step(pre_acc < 4 * N, DW'($urandom), 1'b1);
            if (pre_acc < 4 * N && !obs_sr) stalls++;
            if (started && !obs_mv && pre_out < 4 * N) gaps++;
            if (obs_mv) started = 1'b1;
        end
        check("cont_stalls", stalls, 0);
        check("cont_gaps", gaps, 0);
        check("cont_outputs", n_out - out0, 4 * N);
        drain_and_idle("cont");

        // Downstream stalled for 40 cycles while three frames are offered.
        acc0 = n_acc; out0 = n_out;
        for (int c = 0; c < 40; c++) begin
            step((n_acc - acc0) < 3 * N, DW'($urandom), 1'b0);
        end
        check("bp_accepted", n_acc - acc0, 2 * N);
        check("bp_ready_low", obs_sr, 0);
        guard = 0;
        while (((n_acc - acc0) < 3 * N || (n_out - out0) < 3 * N) && guard < 400) begin
            step((n_acc - acc0) < 3 * N, DW'($urandom), 1'b1);
            guard++;
        end
        check("bp_outputs", n_out - out0, 3 * N);
        drain_and_idle("bp");

        // Random valid/ready over 100 frames.
        acc0 = n_acc; out0 = n_out; guard = 0;
        while (((n_acc - acc0) < 100 * N || (n_out - out0) < 100 * N) && guard < 20000) begin
            step(((n_acc - acc0) < 100 * N) && ($urandom_range(1, 0) == 1),
                 DW'($urandom), $urandom_range(1, 0) == 1);
            guard++;
        end
        check("rand_accepted", n_acc - acc0, 100 * N);
        check("rand_outputs", n_out - out0, 100 * N);
        drain_and_idle("rand");

`ifdef BITR_REORDER_BYPASS_EN
        // Bypass-tagged frame replays in natural order, the next one permuted.
        out0 = n_out;
        cfg_bypass = 1'b1;
        for (int i = 0; i < N; i++) step(1'b1, DW'(300 + i), 1'b1);
        cfg_bypass = 1'b0;
        for (int i = 0; i < N; i++) step(1'b1, DW'(400 + i), 1'b1);
        drain_and_idle("bypass");
        check("bypass_outputs", n_out - out0, 2 * N);
`endif

        // Reset mid-frame at write index 7 of the second frame.
        for (int i = 0; i < N + 7; i++) begin
            step(1'b1, DW'($urandom), 1'b1);
        end
        rst_n = 1'b0;
        step(1'b1, DW'($urandom), 1'b1);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1);
        check_reset_values("midrst");
        out0 = n_out;
        for (int i = 0; i < N; i++) step(1'b1, DW'(200 + i), 1'b1);
        drain_and_idle("fresh");
        check("fresh_outputs", n_out - out0, N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
